// File: rtl/rng_mole_multi.sv
`timescale 1ns/1ps
// Multi-channel random delay generator for the whack-a-mole game: one Galois LFSR shared by
// all mole channels, level-dependent rejection window and per-mole repeat suppression.
module rng_mole_multi #(
  parameter int                NUM_MOLES  = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter int                SEED       = 340,
  parameter int                VAL_W      = 11,
  parameter int                OFFSET     = 300,
  parameter int                LVL_OFFSET = 100,
  parameter int                MAX_VALUE  = 1223,
  parameter int                MAX_TRIES  = 8,
  localparam int               ID_W       = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        level,
  input  logic              req,
  input  logic [ID_W-1:0]   req_id,
  output logic              req_ready,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              valid,
  output logic [VAL_W-1:0]  value,
  output logic [ID_W-1:0]   value_id,
  input  logic              value_ack
);

  localparam int WW    = VAL_W + 2;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int NCH   = 1 << ID_W;
  localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);

  typedef enum logic [1:0] {IDLE, DRAW, OUT} state_t;

  state_t                    state, state_nx;
  logic [LFSR_W-1:0]         lfsr;
  logic [ID_W-1:0]           cur_id;
  logic [1:0]                lvl_q;
  logic [TRY_W-1:0]          try_cnt;
  logic [NCH-1:0][VAL_W-1:0] last_val;
  logic [NCH-1:0]            last_vld;
  logic [VAL_W-1:0]          raw;
  logic                      rep_hit;
  logic                      draw_ok;
  logic                      give_up;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Both bounds tested through the sign of a difference, so a zero lower bound needs no special case.
  function automatic logic win_check(input logic [VAL_W-1:0] r, input logic [1:0] lvl);
    logic signed [WW:0] hi;
    logic signed [WW:0] d_lo;
    logic signed [WW:0] d_hi;
    hi   = (WW+1)'(MAX_VALUE) - (WW+1)'(int'(lvl) * LVL_OFFSET);
    d_lo = $signed({3'b000, r}) - (WW+1)'(OFFSET);
    d_hi = hi - $signed({3'b000, r});
    return !d_lo[WW] && !d_hi[WW];
  endfunction

  assign raw       = lfsr[VAL_W-1:0];
  assign rep_hit   = last_vld[cur_id] && (raw == last_val[cur_id]);
  assign draw_ok   = win_check(raw, lvl_q) && !rep_hit;
  assign give_up   = !draw_ok && (try_cnt == TRY_W'(MAX_TRIES - 1));
  assign req_ready = (state == IDLE);

  // A seed load replaces the advance but never touches the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED_V;
    end else if (seed_load) begin
      lfsr <= (seed_in == '0) ? SEED_V : seed_in;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = DRAW;
      DRAW:    if (draw_ok || give_up) state_nx = OUT;
      OUT:     if (value_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      value    <= '0;
      value_id <= '0;
      try_cnt  <= '0;
      cur_id   <= '0;
      lvl_q    <= '0;
      last_val <= '0;
      last_vld <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cur_id <= req_id;
            lvl_q  <= level;
          end
        end
        DRAW: begin
          if (draw_ok) begin
            valid            <= 1'b1;
            value            <= raw;
            value_id         <= cur_id;
            last_val[cur_id] <= raw;
            last_vld[cur_id] <= 1'b1;
          end else if (give_up) begin
            // Fallback bypasses the repeat check but still becomes this mole's last value.
            valid            <= 1'b1;
            value            <= VAL_W'(OFFSET);
            value_id         <= cur_id;
            last_val[cur_id] <= VAL_W'(OFFSET);
            last_vld[cur_id] <= 1'b1;
            try_cnt          <= try_cnt + 1'b1;
          end else begin
            try_cnt <= try_cnt + 1'b1;
          end
        end
        OUT: begin
          if (value_ack) begin
            valid   <= 1'b0;
            try_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_mole_multi.sv
`timescale 1ns/1ps
// Bench for rng_mole_multi: four differently parametrised instances, a reference LFSR per
// instance and a queue of expected results checked as each result appears.
module tb_rng_mole_multi;
  localparam int NI = 4;
  localparam int MT = 8;
  localparam int P_OFF  [NI] = '{300, 0, 0, 2000};
  localparam int P_MAX  [NI] = '{1223, 2047, 1, 2000};
  localparam int P_LVO  [NI] = '{100, 0, 0, 0};
  localparam int P_VW   [NI] = '{11, 11, 1, 11};
  localparam int P_SEED [NI] = '{340, 1, 340, 340};

  typedef struct {
    int val;
    int id;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NI-1:0]       req_a = '0;
  logic [NI-1:0]       seed_load_a = '0;
  logic [NI-1:0]       value_ack_a = '0;
  logic [NI-1:0][1:0]  req_id_a = '0;
  logic [NI-1:0][1:0]  level_a = '0;
  logic [NI-1:0][15:0] seed_in_a = '0;
  wire  [NI-1:0]       ready_w;
  wire  [NI-1:0]       valid_w;
  wire  [NI-1:0][10:0] value_w;
  wire  [NI-1:0][1:0]  vid_w;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [15:0] lfsr_m [NI];
  int   last_m [NI][4];
  bit   lastv_m [NI][4];

  always #5 clk = ~clk;

  rng_mole_multi u_dut (
    .clk(clk), .reset(reset), .level(level_a[0]), .req(req_a[0]), .req_id(req_id_a[0]),
    .req_ready(ready_w[0]), .seed_load(seed_load_a[0]), .seed_in(seed_in_a[0]),
    .valid(valid_w[0]), .value(value_w[0]), .value_id(vid_w[0]), .value_ack(value_ack_a[0])
  );

  rng_mole_multi #(.OFFSET(0), .LVL_OFFSET(0), .MAX_VALUE(2047), .SEED(1)) u_first (
    .clk(clk), .reset(reset), .level(level_a[1]), .req(req_a[1]), .req_id(req_id_a[1]),
    .req_ready(ready_w[1]), .seed_load(seed_load_a[1]), .seed_in(seed_in_a[1]),
    .valid(valid_w[1]), .value(value_w[1]), .value_id(vid_w[1]), .value_ack(value_ack_a[1])
  );

  rng_mole_multi #(.NUM_MOLES(1), .VAL_W(1), .OFFSET(0), .MAX_VALUE(1), .LVL_OFFSET(0)) u_rep (
    .clk(clk), .reset(reset), .level(level_a[2]), .req(req_a[2]), .req_id(req_id_a[2][0:0]),
    .req_ready(ready_w[2]), .seed_load(seed_load_a[2]), .seed_in(seed_in_a[2]),
    .valid(valid_w[2]), .value(value_w[2][0:0]), .value_id(vid_w[2][0:0]), .value_ack(value_ack_a[2])
  );
  assign value_w[2][10:1] = '0;
  assign vid_w[2][1] = 1'b0;

  rng_mole_multi #(.OFFSET(2000), .MAX_VALUE(2000), .LVL_OFFSET(0)) u_fb (
    .clk(clk), .reset(reset), .level(level_a[3]), .req(req_a[3]), .req_id(req_id_a[3]),
    .req_ready(ready_w[3]), .seed_load(seed_load_a[3]), .seed_in(seed_in_a[3]),
    .valid(valid_w[3]), .value(value_w[3]), .value_id(vid_w[3]), .value_ack(value_ack_a[3])
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) lfsr_m[i] <= 16'(P_SEED[i]);
      else if (seed_load_a[i]) lfsr_m[i] <= (seed_in_a[i] == 16'h0) ? 16'(P_SEED[i]) : seed_in_a[i];
      else lfsr_m[i] <= step(lfsr_m[i]);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_model();
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 4; j++) begin
        last_m[i][j] = 0;
        lastv_m[i][j] = 1'b0;
      end
  endtask

  // Called just after the accepting edge: the model register then holds the first raw draw.
  task automatic predict(input int inst, input int lvl, input int id);
    logic [15:0] st;
    int hi, mask, raw;
    exp_t e;
    st = lfsr_m[inst];
    hi = P_MAX[inst] - lvl * P_LVO[inst];
    mask = (1 << P_VW[inst]) - 1;
    e.id = id;
    e.val = P_OFF[inst];
    e.lat = MT;
    for (int k = 0; k < MT; k++) begin
      raw = int'(st) & mask;
      if (raw >= P_OFF[inst] && raw <= hi && !(lastv_m[inst][id] && raw == last_m[inst][id])) begin
        e.val = raw;
        e.lat = k + 1;
        break;
      end
      st = step(st);
    end
    last_m[inst][id] = e.val;
    lastv_m[inst][id] = 1'b1;
    sb.push_back(e);
  endtask

  task automatic issue(input int inst, input int lvl, input int id);
    int w;
    w = 0;
    @(negedge clk);
    while (ready_w[inst] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (ready_w[inst] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready inst=%0d: req_ready=%b, required 1", inst, ready_w[inst]);
    end
    req_a[inst] = 1'b1;
    req_id_a[inst] = 2'(id);
    level_a[inst] = 2'(lvl);
    @(posedge clk);
    #1;
    req_a[inst] = 1'b0;
    level_a[inst] = 2'($urandom_range(0, 3));
    predict(inst, lvl, id);
  endtask

  task automatic collect(input int inst, output int v, output int lat);
    exp_t e;
    v = -1;
    lat = 0;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty inst=%0d: queue size 0, required an entry", inst);
      return;
    end
    e = sb.pop_front();
    for (int n = 1; n <= MT + 2; n++) begin
      @(posedge clk);
      #1;
      if (valid_w[inst] === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat != e.lat) begin
      n_fail++;
      $display("FAIL latency inst=%0d: got %0d cycles, required %0d", inst, lat, e.lat);
    end
    v = int'(value_w[inst]);
    n_chk++;
    if (value_w[inst] !== 11'(e.val)) begin
      n_fail++;
      $display("FAIL value inst=%0d: got %0d, required %0d", inst, value_w[inst], e.val);
    end
    n_chk++;
    if (vid_w[inst] !== 2'(e.id)) begin
      n_fail++;
      $display("FAIL value_id inst=%0d: got %0d, required %0d", inst, vid_w[inst], e.id);
    end
  endtask

  task automatic ack(input int inst);
    @(negedge clk);
    value_ack_a[inst] = 1'b1;
    @(posedge clk);
    #1;
    value_ack_a[inst] = 1'b0;
    n_chk++;
    if (valid_w[inst] !== 1'b0 || ready_w[inst] !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_release inst=%0d: valid=%b ready=%b, required valid=0 ready=1",
               inst, valid_w[inst], ready_w[inst]);
    end
  endtask

  task automatic test_reset();
    int v, lat;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (valid_w[i] !== 1'b0 || ready_w[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ctrl inst=%0d: valid=%b ready=%b, required 0/1", i, valid_w[i], ready_w[i]);
      end
      n_chk++;
      if (value_w[i] !== 11'd0 || vid_w[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_data inst=%0d: value=%0d id=%0d, required 0/0", i, value_w[i], vid_w[i]);
      end
    end
    // reset while drawing
    @(negedge clk);
    req_a[0] = 1'b1;
    req_id_a[0] = 2'd1;
    @(posedge clk);
    #1;
    req_a[0] = 1'b0;
    n_chk++;
    if (ready_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL draw_entry: req_ready=%b, required 0", ready_w[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (valid_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_draw: valid=%b ready=%b, required 0/1", valid_w[0], ready_w[0]);
    end
    clear_model();
    // reset while holding a result
    issue(0, 0, 2);
    collect(0, v, lat);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (valid_w[0] !== 1'b0 || ready_w[0] !== 1'b1 || value_w[0] !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_in_out: valid=%b ready=%b value=%0d, required 0/1/0",
               valid_w[0], ready_w[0], value_w[0]);
    end
    clear_model();
  endtask

  task automatic test_first_draw();
    int v, lat;
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_a[1] = 1'b1;
    req_id_a[1] = 2'd2;
    @(posedge clk);
    #1;
    req_a[1] = 1'b0;
    clear_model();
    e.val = 1024;
    e.id = 2;
    e.lat = 1;
    sb.push_back(e);
    last_m[1][2] = 1024;
    lastv_m[1][2] = 1'b1;
    collect(1, v, lat);
    ack(1);
  endtask

  task automatic test_level_sweep();
    int v, lat, hi;
    for (int lvl = 0; lvl < 4; lvl++) begin
      hi = 1223 - 100 * lvl;
      for (int d = 0; d < 200; d++) begin
        issue(0, lvl, int'($urandom_range(0, 3)));
        collect(0, v, lat);
        n_chk++;
        if (!((v >= 300 && v <= hi) || v == 300)) begin
          n_fail++;
          $display("FAIL window lvl=%0d: got %0d, required within [300,%0d]", lvl, v, hi);
        end
        ack(0);
      end
    end
  endtask

  task automatic test_repeat();
    int v, lat, prev;
    prev = -1;
    for (int d = 0; d < 50; d++) begin
      issue(2, 0, 0);
      collect(2, v, lat);
      if (lat < MT && prev >= 0) begin
        n_chk++;
        if (v == prev) begin
          n_fail++;
          $display("FAIL repeat d=%0d: got %0d equal to previous, required %0d", d, v, 1 - prev);
        end
      end
      prev = v;
      ack(2);
    end
  endtask

  task automatic test_fallback();
    int v, lat;
    for (int d = 0; d < 30; d++) begin
      issue(3, 0, d % 4);
      collect(3, v, lat);
      n_chk++;
      if (v != 2000) begin
        n_fail++;
        $display("FAIL fallback_value d=%0d: got %0d, required 2000", d, v);
      end
      n_chk++;
      if (lat < 1 || lat > MT) begin
        n_fail++;
        $display("FAIL fallback_latency d=%0d: got %0d, required 1..%0d", d, lat, MT);
      end
      ack(3);
    end
  endtask

  task automatic test_handshake();
    int v, lat;
    issue(0, 1, 1);
    collect(0, v, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_a[0] = 1'b1;
      req_id_a[0] = 2'd3;
      @(posedge clk);
      #1;
      n_chk++;
      if (valid_w[0] !== 1'b1 || int'(value_w[0]) != v || vid_w[0] !== 2'd1 || ready_w[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold c=%0d: valid=%b value=%0d id=%0d ready=%b, required 1/%0d/1/0",
                 c, valid_w[0], value_w[0], vid_w[0], ready_w[0], v);
      end
    end
    req_a[0] = 1'b0;
    ack(0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (valid_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL no_queue c=%0d: valid=%b ready=%b, required 0/1", c, valid_w[0], ready_w[0]);
      end
    end
  endtask

  task automatic test_reseed();
    int v, lat;
    @(negedge clk);
    seed_load_a[1] = 1'b1;
    seed_in_a[1] = 16'h0000;
    @(posedge clk);
    #1;
    seed_load_a[1] = 1'b0;
    issue(1, 0, 3);
    collect(1, v, lat);
    n_chk++;
    if (v != 1024 || lat != 1) begin
      n_fail++;
      $display("FAIL reseed_zero: value=%0d latency=%0d, required 1024/1", v, lat);
    end
    ack(1);
    @(negedge clk);
    seed_load_a[1] = 1'b1;
    seed_in_a[1] = 16'h1234;
    @(posedge clk);
    #1;
    seed_load_a[1] = 1'b0;
    issue(1, 0, 0);
    collect(1, v, lat);
    ack(1);
  endtask

  task automatic test_seed_mid_draw();
    int v, lat;
    issue(3, 0, 0);
    fork
      begin
        @(negedge clk);
        seed_load_a[3] = 1'b1;
        seed_in_a[3] = 16'($urandom);
        @(posedge clk);
        #1;
        seed_load_a[3] = 1'b0;
      end
    join_none
    collect(3, v, lat);
    ack(3);
    issue(0, 2, 1);
    fork
      begin
        @(negedge clk);
        seed_load_a[0] = 1'b1;
        seed_in_a[0] = 16'hACE1;
        @(posedge clk);
        #1;
        seed_load_a[0] = 1'b0;
      end
    join_none
    sb.delete();
    for (int n = 1; n <= MT + 2 && valid_w[0] !== 1'b1; n++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (valid_w[0] !== 1'b1 || vid_w[0] !== 2'd1 ||
        !(int'(value_w[0]) >= 300 && int'(value_w[0]) <= 1023)) begin
      n_fail++;
      $display("FAIL seed_mid_draw: valid=%b id=%0d value=%0d, required 1/1/in [300,1023]",
               valid_w[0], vid_w[0], value_w[0]);
    end
    ack(0);
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_level_sweep();
    test_repeat();
    test_fallback();
    test_handshake();
    test_reseed();
    test_seed_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
